// File: rtl/switch_input_port_if.sv
// Processor-side handshake bundle for the switch input port:
// request/ack from the processor, captured data plus status back to it.
interface switch_input_port_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  ack;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  waiting;

    // Processor drives req/ack and consumes data/status
    modport master (
        output req,
        output ack,
        input  data,
        input  valid,
        input  waiting
    );

    // Input port consumes req/ack and returns data/status
    modport slave (
        input  req,
        input  ack,
        output data,
        output valid,
        output waiting
    );
endinterface

// File: rtl/switch_input_port.sv
// Switch input port: synchronizes the slide switches and a bouncing
// active-low pushbutton, debounces the button, and hands one captured
// switch value to the processor per key press over a valid/ack handshake.
module switch_input_port #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sw_i,
    input  logic                  key_i,
    switch_input_port_if.slave    proc
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The debounced level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES-1, so the compare value is one below that.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        VALID        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic                  key_meta_q, key_sync_q;
    logic [1:0]            fill_q;
    logic                  armed_q, armed_d;
    logic                  key_db_q, key_db_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  press_evt;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  waiting_q, waiting_d;

    // Two-flop synchronizers for the asynchronous switch and key inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            sw_meta_q  <= sw_i;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= key_i;
            key_sync_q <= key_meta_q;
        end
    end

    // Debouncer next-state: count differing cycles, flip level when stable
    // long enough. Press events need the key to have been seen released
    // since reset (armed), so a key held through reset cannot fire.
    always_comb begin
        key_db_d  = key_db_q;
        cnt_d     = '0;
        press_evt = 1'b0;
        armed_d   = armed_q | (fill_q[1] & key_sync_q);
        if (key_sync_q != key_db_q) begin
            if (cnt_q == CNT_LAST) begin
                key_db_d  = key_sync_q;
                press_evt = key_db_q & armed_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debouncer state; fill_q marks when the sync pipe holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_q <= 1'b1;
            cnt_q    <= '0;
            fill_q   <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            key_db_q <= key_db_d;
            cnt_q    <= cnt_d;
            fill_q   <= {fill_q[0], 1'b1};
            armed_q  <= armed_d;
        end
    end

    // Handshake FSM next-state, capture, and registered-output next values
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (proc.req) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!proc.req) begin
                    state_d = IDLE;
                end else if (press_evt) begin
                    data_d  = sw_sync_q;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (proc.ack) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (key_db_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        valid_d   = (state_d == VALID);
        waiting_d = (state_d == WAIT_PRESS);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            waiting_q <= waiting_d;
        end
    end

    assign proc.data    = data_q;
    assign proc.valid   = valid_q;
    assign proc.waiting = waiting_q;

endmodule
